fifo_rd_ctrl: RTL and testbench
===============================

Name: fifo_rd_ctrl

Overview:
- Read-side controller of the async FIFO, in the read clock domain.
- Takes the write pointer (Gray, launched from the write domain) and synchronises it, then converts it to binary.
- Derives empty and fill level, drives the dual-port RAM read port, and presents data on a valid/ready stream.
- Returns its own read pointer as registered Gray for the write side. rst_n comes from the per-domain reset synchroniser.

Parameters:
- ADDR_W, 4, RAM address width; FIFO depth = 2**ADDR_W.
- DATA_W, 8, data width.
- SYNC_STAGES, 2, synchroniser flops on the incoming write pointer; legal range 2..4.

Ports:
- clk  in  1  read-domain clock.
- rst_n  in  1  asynchronous, active-low reset.
- wr_ptr_gray  in  ADDR_W+1  write pointer, Gray, asynchronous to clk.
- rd_ptr_gray  out  ADDR_W+1  read pointer, Gray, registered, to the write domain.
- ram_raddr  out  ADDR_W  RAM read address (= rd_ptr_bin[ADDR_W-1:0]).
- ram_ren  out  1  RAM read enable.
- ram_rdata  in  DATA_W  RAM read data, valid 1 clk after ram_ren.
- m_data  out  DATA_W  output data.
- m_valid  out  1  output valid.
- m_ready  in  1  consumer ready.
- empty  out  1  no unread RAM entries (internal pointer view).
- rd_level  out  ADDR_W+1  synced_wr_bin - rd_ptr_bin, modulo 2**(ADDR_W+1).
- ptr_err  out  1  sticky pointer-consistency error.

Behaviour:
Reset (async assert, clk-synchronous release):
- All flops 0, so rd_ptr_gray=0, ram_ren=0, m_valid=0, m_data=0, empty=1, rd_level=0, ptr_err=0.

Pointer synchroniser and conversion:
- wr_ptr_gray passes through a SYNC_STAGES flop chain.
- The last stage is converted Gray-to-binary and registered into wr_bin.
- A change on wr_ptr_gray is reflected in empty/rd_level SYNC_STAGES+1 edges later.

Empty and level:
- empty = (wr_bin == rd_ptr_bin), combinational from registers.
- rd_level = wr_bin - rd_ptr_bin, wrap-safe unsigned subtract.

RAM read port:
- ram_ren = !empty && credit>0.
- On an ren edge: rd_ptr_bin increments and wraps from 2**(ADDR_W+1)-1 to 0.
- rd_ptr_gray <= bin2gray of the incremented value, registered, so exactly one bit changes per step.
- ram_raddr = current rd_ptr_bin low bits.

Output buffer:
- 2-entry skid FIFO (occ 0..2) with an inflight flag (ren issued last cycle).
- credit = 2 - occ - inflight + pop, where pop = m_valid && m_ready. This sustains 1 word/clk.
- inflight data is written into the buffer on the next edge.
- m_valid = occ>0; m_data = head entry.
- m_data is stable while m_valid && !m_ready.
- Push and pop in the same cycle keep occ unchanged.

Latency from idle:
- m_valid rises SYNC_STAGES+3 edges after wr_ptr_gray changes: sync, wr_bin register, ren edge, buffer capture.

ptr_err (cleared only by rst_n). Set, sticky, if either:
- consecutive synced Gray samples differ in more than 1 bit, or
- rd_level > 2**ADDR_W.

Boundaries:
- Full depth (rd_level=16 for ADDR_W=4) is legal and drains normally.
- Pointer wrap past 31 is seamless.
- m_ready held low: after the buffer fills (occ=2), ram_ren stays 0 and no data is lost.
- A write-pointer update and a read in the same cycle are independent; level is recomputed next cycle.
- Reset mid-operation discards buffered and inflight data. The write domain must be reset in the same event; this is a system requirement, not checked here.

Decomposition:
- Shared package fifo_pkg: default ADDR_W/DATA_W, a bin2gray function, and a pointer-width constant function (ADDR_W+1).
- Sub-module: instantiate the existing gray2bin block (N=ADDR_W+1) for the conversion.
- The synchroniser chain stays inline.

Test Plan (ADDR_W=4, DATA_W=8, SYNC_STAGES=2, RAM model 1-clk latency, word k = 8'hA0+k):
- Reset check: reset, then release with wr_ptr_gray=0 -> empty=1, rd_level=0, m_valid=0, rd_ptr_gray=0, ram_ren=0 for 10 clk.
- Single word: wr_ptr_gray 0->1 -> empty falls after 3 edges; ram_ren one cycle with raddr=0; m_valid rises at edge 5 with m_data=A0; rd_ptr_gray=1; empty=1 after pop.
- Full-rate burst: wr_ptr_gray stepped to gray(16), m_ready=1 -> 16 words A0..AF, m_valid continuous once started, rd_level 16 -> 0, final rd_ptr_gray=gray(16)=5'b11000.
- Backpressure: 8 words queued, m_ready=0 -> occ=2, ram_ren=0, m_data=A0 stable. m_ready then toggled 1/0 -> order A0..A7 preserved, no duplicates.
- Wrap: 40 words written/read in chunks of 5 -> pointer wraps 31->0, data order intact, ptr_err=0.
- Error and reset: wr_ptr_gray jumps 0->5'b00011 -> ptr_err=1 and stays 1; assert rst_n mid-burst -> all outputs return to reset values within 0 clk, ptr_err=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// ------------------------------------------------------------------
// fifo_pkg: shared async-FIFO defaults and pointer helpers.  rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package fifo_pkg;

   localparam int DEF_ADDR_W      = 4;
   localparam int DEF_DATA_W      = 8;
   localparam int DEF_SYNC_STAGES = 2;

   // One extra MSB distinguishes full from empty when the address bits match.
   function automatic int ptr_w(input int addr_w);
      return addr_w + 1;
   endfunction

   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/gray2bin.sv
// ------------------------------------------------------------------
// gray2bin: combinational Gray-to-binary converter.          rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module gray2bin #(
   parameter int N = 5
) (
   input  logic [N-1:0] gray,
   output logic [N-1:0] bin
);

   // Each binary bit is the XOR of all Gray bits at or above it.
   for (genvar i = 0; i < N; i++) begin : g_bit
      assign bin[i] = ^gray[N-1:i];
   end

endmodule

`default_nettype wire

// File: rtl/fifo_rd_ctrl.sv
// ------------------------------------------------------------------
// fifo_rd_ctrl: async FIFO read-side controller.              rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module fifo_rd_ctrl
   import fifo_pkg::*;
#(
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [ptr_w(ADDR_W)-1:0] wr_ptr_gray,
   output logic [ptr_w(ADDR_W)-1:0] rd_ptr_gray,
   output logic [ADDR_W-1:0]        ram_raddr,
   output logic                     ram_ren,
   input  logic [DATA_W-1:0]        ram_rdata,
   output logic [DATA_W-1:0]        m_data,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic                     empty,
   output logic [ptr_w(ADDR_W)-1:0] rd_level,
   output logic                     ptr_err
);

   localparam int            PW    = ptr_w(ADDR_W);
   localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

   logic [PW-1:0]     sync_q [SYNC_STAGES];
   logic [PW-1:0]     gray_last;
   logic [PW-1:0]     prev_gray;
   logic [PW-1:0]     sync_bin;
   logic [PW-1:0]     wr_bin;
   logic [PW-1:0]     rd_ptr_bin;
   logic [PW-1:0]     rd_ptr_next;
   logic [PW-1:0]     gray_diff;
   logic              gray_jump;
   logic              level_over;

   logic [DATA_W-1:0] skid_q [2];
   logic              head;
   logic              wr_idx;
   logic [1:0]        occ;
   logic              inflight;
   logic              pop;

   // ---------------- write-pointer synchroniser ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= wr_ptr_gray;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign gray_last = sync_q[SYNC_STAGES-1];

   gray2bin #(
      .N    (PW)
   ) u_gray2bin (
      .gray (gray_last),
      .bin  (sync_bin)
   );

   // A legal Gray stream never changes more than one bit between samples.
   assign gray_diff  = gray_last ^ prev_gray;
   assign gray_jump  = |(gray_diff & (gray_diff - PW'(1)));
   assign level_over = (rd_level > DEPTH);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_bin    <= '0;
         prev_gray <= '0;
         ptr_err   <= 1'b0;
      end else begin
         wr_bin    <= sync_bin;
         prev_gray <= gray_last;
         ptr_err   <= ptr_err | gray_jump | level_over;
      end
   end

   assign empty    = (wr_bin == rd_ptr_bin);
   assign rd_level = wr_bin - rd_ptr_bin;

   // ---------------- RAM read port ----------------
   assign pop         = m_valid & m_ready;
   // Credit = 2 - occ - inflight + pop, rearranged to avoid a signed compare.
   assign ram_ren     = !empty &&
                        (({1'b0, occ} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));
   assign ram_raddr   = rd_ptr_bin[ADDR_W-1:0];
   assign rd_ptr_next = rd_ptr_bin + PW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_bin  <= '0;
         rd_ptr_gray <= '0;
      end else if (ram_ren) begin
         rd_ptr_bin  <= rd_ptr_next;
         rd_ptr_gray <= PW'(bin2gray(32'(rd_ptr_next)));
      end
   end

   // ---------------- 2-entry skid buffer ----------------
   // Tail slot is head^occ[0]; with occ=2 a push only happens alongside a
   // pop, so it reuses the slot being freed.
   assign wr_idx  = head ^ occ[0];
   assign m_valid = (occ != 2'd0);
   assign m_data  = skid_q[head];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         skid_q[0] <= '0;
         skid_q[1] <= '0;
         head      <= 1'b0;
         occ       <= 2'd0;
         inflight  <= 1'b0;
      end else begin
         inflight <= ram_ren;
         if (inflight) begin
            skid_q[wr_idx] <= ram_rdata;
         end
         if (pop) begin
            head <= ~head;
         end
         occ <= occ + {1'b0, inflight} - {1'b0, pop};
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_ctrl.sv
// ------------------------------------------------------------------
// tb_fifo_rd_ctrl: randomized bench with a pointer-count model.  rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_fifo_rd_ctrl;

   localparam int AW = 4;
   localparam int DW = 8;
   localparam int SS = 2;

   logic          clk;
   logic          rst_n;
   logic [AW:0]   wr_ptr_gray;
   logic [AW:0]   rd_ptr_gray;
   logic [AW-1:0] ram_raddr;
   logic          ram_ren;
   logic [DW-1:0] ram_rdata;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_ready;
   logic          empty;
   logic [AW:0]   rd_level;
   logic          ptr_err;

   fifo_rd_ctrl #(
      .ADDR_W      (AW),
      .DATA_W      (DW),
      .SYNC_STAGES (SS)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_ptr_gray (wr_ptr_gray),
      .rd_ptr_gray (rd_ptr_gray),
      .ram_raddr   (ram_raddr),
      .ram_ren     (ram_ren),
      .ram_rdata   (ram_rdata),
      .m_data      (m_data),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .empty       (empty),
      .rd_level    (rd_level),
      .ptr_err     (ptr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [AW:0] gray(input int b);
      logic [AW:0] v;
      v = (AW+1)'(b);
      return v ^ (v >> 1);
   endfunction

   function automatic int g2b(input logic [AW:0] g);
      logic [AW:0] b;
      b[AW] = g[AW];
      for (int i = AW - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return int'(b);
   endfunction

   // RAM model: word k lives at k mod depth, read data one clock after ren.
   logic [DW-1:0] mem [2**AW];
   always @(posedge clk) if (ram_ren) ram_rdata <= mem[ram_raddr];

   // Stimulus-side state.
   int wp         = 0;
   int ready_mode = 1;
   bit chk_data   = 1;

   // Model state: counts of reads issued/popped and the delayed write pointer.
   int          n_ren, n_pop, last_ren, prev_lvl;
   bit          exp_err;
   logic [AW:0] hist [SS+2];

   always @(negedge clk) begin
      int exp_wr, exp_lvl, exp_occ, outst;
      bit ev, er, pp;
      if (!rst_n) begin
         n_ren = 0; n_pop = 0; last_ren = 0; prev_lvl = 0; exp_err = 0;
         foreach (hist[i]) hist[i] = '0;
      end else if ($countones(hist[SS] ^ hist[SS+1]) > 1 || prev_lvl > 2**AW) begin
         exp_err = 1;
      end
      exp_wr  = g2b(hist[SS]);
      exp_lvl = (exp_wr - n_ren) & (2**(AW+1) - 1);
      exp_occ = n_ren - last_ren - n_pop;
      ev      = exp_occ > 0;
      pp      = ev && m_ready;
      outst   = n_ren - n_pop;
      er      = (exp_lvl != 0) && (outst < 2 + int'(pp));

      check("rd_ptr_gray", 32'(rd_ptr_gray), 32'(gray(n_ren)));
      check("ram_raddr",   32'(ram_raddr),   32'(n_ren % (2**AW)));
      check("ram_ren",     32'(ram_ren),     32'(er));
      check("empty",       32'(empty),       32'(exp_lvl == 0));
      check("rd_level",    32'(rd_level),    32'(exp_lvl));
      check("m_valid",     32'(m_valid),     32'(ev));
      check("ptr_err",     32'(ptr_err),     32'(exp_err));
      if (!rst_n)
         check("m_data_rst", 32'(m_data), 32'h0);
      else if (ev && chk_data)
         check("m_data", 32'(m_data), 32'((8'hA0 + n_pop) & 8'hFF));

      if (rst_n) begin
         n_ren    += int'(er);
         last_ren  = int'(er);
         n_pop    += int'(pp);
         prev_lvl  = exp_lvl;
         for (int i = SS + 1; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = wr_ptr_gray;
      end
   end

   initial begin
      m_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (ready_mode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            default: m_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   task automatic apply_reset(input bit check_now);
      @(posedge clk); #2;
      rst_n       = 1'b0;
      wr_ptr_gray = '0;
      wp          = 0;
      #1;
      if (check_now) begin
         check("rst_m_valid",  32'(m_valid),     32'h0);
         check("rst_ram_ren",  32'(ram_ren),     32'h0);
         check("rst_empty",    32'(empty),       32'h1);
         check("rst_level",    32'(rd_level),    32'h0);
         check("rst_rd_gray",  32'(rd_ptr_gray), 32'h0);
         check("rst_ptr_err",  32'(ptr_err),     32'h0);
         check("rst_m_data",   32'(m_data),      32'h0);
      end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic write_words(input int n);
      for (int i = 0; i < n; i++) begin
         int guard = 0;
         while (wp - n_pop >= 2**AW && guard < 1000) begin
            @(posedge clk);
            guard++;
         end
         if (guard >= 1000) check("writer_timeout", 32'h0, 32'h1);
         @(posedge clk); #1;
         mem[wp % (2**AW)] = DW'(8'hA0 + wp);
         wp++;
         wr_ptr_gray = gray(wp);
      end
   endtask

   task automatic wait_drain();
      int guard = 0;
      while (n_pop != wp && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 2000) check("drain_timeout", 32'h0, 32'h1);
      repeat (4) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst_n       = 1'b1;
      wr_ptr_gray = '0;
      #1 rst_n = 1'b0;
      ready_mode = 1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Idle after reset.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("idle_empty",   32'(empty),       32'h1);
         check("idle_level",   32'(rd_level),    32'h0);
         check("idle_m_valid", 32'(m_valid),     32'h0);
         check("idle_rd_gray", 32'(rd_ptr_gray), 32'h0);
         check("idle_ram_ren", 32'(ram_ren),     32'h0);
      end

      // Single word: fixed latency through sync, wr_bin, ren, capture.
      write_words(1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("sw_empty_e3", 32'(empty),     32'h0);
      check("sw_ren_e3",   32'(ram_ren),   32'h1);
      check("sw_raddr_e3", 32'(ram_raddr), 32'h0);
      @(negedge clk);
      check("sw_valid_e4", 32'(m_valid),   32'h0);
      @(negedge clk);
      check("sw_valid_e5", 32'(m_valid),   32'h1);
      check("sw_data_e5",  32'(m_data),    32'hA0);
      repeat (3) @(negedge clk);
      check("sw_rd_gray",  32'(rd_ptr_gray), 32'h01);
      check("sw_empty",    32'(empty),       32'h1);

      // Full-rate burst of a whole FIFO depth.
      apply_reset(0);
      write_words(16);
      wait_drain();
      check("burst_rd_gray", 32'(rd_ptr_gray), 32'b11000);
      check("burst_level",   32'(rd_level),    32'h0);

      // Backpressure: the buffer fills, reads stop, head word holds.
      apply_reset(0);
      ready_mode = 0;
      write_words(8);
      repeat (20) @(negedge clk);
      check("bp_valid", 32'(m_valid),  32'h1);
      check("bp_data",  32'(m_data),   32'hA0);
      check("bp_ren",   32'(ram_ren),  32'h0);
      check("bp_level", 32'(rd_level), 32'h6);
      ready_mode = 2;
      wait_drain();
      check("bp_rd_gray", 32'(rd_ptr_gray), 32'b01100);
      check("bp_empty",   32'(empty),       32'h1);

      // Wrap: 40 words in chunks of 5, random consumer.
      for (int c = 0; c < 8; c++) begin
         write_words(5);
         repeat ($urandom_range(0, 6)) @(posedge clk);
      end
      wait_drain();
      check("wrap_rd_gray", 32'(rd_ptr_gray), 32'b11000);
      check("wrap_ptr_err", 32'(ptr_err),     32'h0);

      // Random traffic.
      for (int c = 0; c < 30; c++) begin
         write_words($urandom_range(1, 7));
         repeat ($urandom_range(0, 10)) @(posedge clk);
      end
      wait_drain();

      // Illegal Gray jump makes ptr_err sticky.
      apply_reset(0);
      ready_mode = 1;
      chk_data   = 0;
      @(posedge clk); #1;
      wr_ptr_gray = 5'b00011;
      repeat (6) @(negedge clk);
      check("err_set",    32'(ptr_err), 32'h1);
      repeat (10) @(negedge clk);
      check("err_sticky", 32'(ptr_err), 32'h1);

      // Reset mid-burst clears everything immediately.
      apply_reset(1);
      chk_data = 1;
      write_words(10);
      apply_reset(1);
      repeat (5) @(negedge clk);
      check("post_rst_err", 32'(ptr_err), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
